ysyx_23060184_pipe_ctrl: RTL and testbench

Pipeline controller for the five-stage core: tracks per-stage occupancy and drives the valid/ready pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also inserts load-use bubbles, squashes younger instructions on taken control transfers, and sequences ecall/mret through a drain-then-commit state machine. It sits beside the datapath; every pipeline register loads when its upstream valid and downstream ready are both high.

---
 rtl/ysyx_23060184_pipe_ctrl.sv | 116 +++++++++++
 tb/tb_ysyx_23060184_pipe_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060184_pipe_ctrl.sv
// Five-stage pipeline controller: stage occupancy, valid/ready handshakes,
// load-use bubbles, control-transfer squash and trap drain/commit sequencing.
`ifndef REG_LENGTH
`define REG_LENGTH 5
`endif

module ysyx_23060184_pipe_ctrl (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Fvalid,
  input  logic [`REG_LENGTH-1:0] Rs1D,
  input  logic [`REG_LENGTH-1:0] Rs2D,
  input  logic [`REG_LENGTH-1:0] RdE,
  input  logic                   MemReadE,
  input  logic                   TakenE,
  input  logic                   EcallE,
  input  logic                   MretE,
  input  logic                   MemBusy,
  output logic                   Dready,
  output logic                   Dvalid,
  output logic                   Eready,
  output logic                   BubbleE,
  output logic                   Evalid,
  output logic                   Mready,
  output logic                   Mvalid,
  output logic                   FlushD,
  output logic                   RedirectF,
  output logic                   TrapCommit,
  output logic                   TrapIsMret,
  output logic [31:0]            LoadUseCnt
);

  localparam int unsigned REG_W = `REG_LENGTH;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state;
  logic   v_d, v_e, v_m, v_w;

  logic run, commit, trap_e, lu_haz;
  logic move_m, move_e, redir_b, issue, kill_d, lu_stall;

  // Hazard and handshake decode, all same-cycle from state and inputs.
  assign run     = (state == RUN);
  assign commit  = (state == COMMIT);
  assign trap_e  = v_e & (EcallE | MretE);
  assign lu_haz  = v_d & v_e & MemReadE & (RdE != REG_W'(0)) &
                   ((RdE == Rs1D) | (RdE == Rs2D));

  assign move_m  = v_m & ~MemBusy;
  assign Mvalid  = move_m;
  assign Mready  = ~v_m | move_m;

  assign move_e  = v_e & Mready & run & ~trap_e;
  assign Evalid  = move_e;
  assign Eready  = (~v_e | move_e) & run & ~trap_e;

  assign redir_b = move_e & TakenE;
  assign Dvalid  = v_d & ~lu_haz & ~redir_b & run & ~trap_e;
  assign issue   = Dvalid & Eready;
  assign BubbleE = Eready & ~issue;
  assign Dready  = run & ~trap_e & ~redir_b & (~v_d | issue);

  // A trap kills ID at detection; COMMIT also clears the trap instruction in EX.
  assign kill_d     = redir_b | (run & trap_e) | commit;
  assign FlushD     = kill_d;
  assign RedirectF  = redir_b | commit;
  assign TrapCommit = commit;
  assign lu_stall   = lu_haz & run & ~trap_e;

  // Occupancy bits, trap sequencer and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_d        <= 1'b0;
      v_e        <= 1'b0;
      v_m        <= 1'b0;
      v_w        <= 1'b0;
      state      <= RUN;
      TrapIsMret <= 1'b0;
      LoadUseCnt <= '0;
    end else begin
      v_w <= move_m;
      v_m <= move_e | (v_m & ~move_m);

      if (commit)       v_e <= 1'b0;
      else if (issue)   v_e <= 1'b1;
      else if (move_e)  v_e <= 1'b0;

      if (kill_d)                v_d <= 1'b0;
      else if (Fvalid & Dready)  v_d <= 1'b1;
      else if (issue)            v_d <= 1'b0;

      if (lu_stall) LoadUseCnt <= LoadUseCnt + CNT_W'(1);

      case (state)
        RUN: begin
          if (trap_e) begin
            state      <= DRAIN;
            TrapIsMret <= MretE;
          end
        end
        DRAIN: begin
          if (~v_m & ~v_w) state <= COMMIT;
        end
        COMMIT:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_pipe_ctrl.sv
// Bench for the pipeline controller: fixed vectors, hand-built trap/stall
// sequences and random stimulus, all checked against an occupancy model.
module tb_ysyx_23060184_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, Fvalid, MemReadE, TakenE, EcallE, MretE, MemBusy;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       Dready, Dvalid, Eready, BubbleE, Evalid, Mready, Mvalid;
  logic       FlushD, RedirectF, TrapCommit, TrapIsMret;
  logic [31:0] LoadUseCnt;

  ysyx_23060184_pipe_ctrl dut (
    .clk(clk), .reset(reset), .Fvalid(Fvalid),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemReadE(MemReadE), .TakenE(TakenE), .EcallE(EcallE), .MretE(MretE),
    .MemBusy(MemBusy),
    .Dready(Dready), .Dvalid(Dvalid), .Eready(Eready), .BubbleE(BubbleE),
    .Evalid(Evalid), .Mready(Mready), .Mvalid(Mvalid), .FlushD(FlushD),
    .RedirectF(RedirectF), .TrapCommit(TrapCommit), .TrapIsMret(TrapIsMret),
    .LoadUseCnt(LoadUseCnt)
  );

  typedef struct packed {
    logic       rst, fv;
    logic [4:0] rs1, rs2, rd;
    logic       mr, tk, ec, mt, busy;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [9:0]  exp;
    logic [31:0] exp_cnt;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: instruction id held by each stage (D, E, M, W), -1 when empty.
  int          m_id [4];
  int          n_id [4];
  int          m_mode, n_mode;          // 0 run, 1 drain, 2 commit
  int          m_next, n_next;
  logic        m_mret, n_mret;
  logic [31:0] m_cnt, n_cnt;
  logic [9:0]  e_vec;                   // {Dready,Dvalid,Eready,BubbleE,Evalid,Mready,Mvalid,FlushD,RedirectF,TrapCommit}

  function automatic stim_t mk(input logic rst, input logic fv, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                               input logic tk, input logic ec, input logic mt, input logic busy);
    stim_t s;
    s.rst = rst; s.fv = fv; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.mr = mr; s.tk = tk; s.ec = ec; s.mt = mt; s.busy = busy;
    return s;
  endfunction

  function automatic logic [9:0] dut_vec();
    return {Dready, Dvalid, Eready, BubbleE, Evalid, Mready, Mvalid, FlushD, RedirectF, TrapCommit};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL cyc=%0d %s actual=%0h required=%0h", cyc, nm, act, req);
    end
  endtask

  task automatic model_eval(input stim_t s);
    bit od, oe, om, ow, run, cmt, trap, lu, memgo, mroom, exgo, exroom;
    bit redir, idgo, iss, idroom, kill;
    od = m_id[0] >= 0; oe = m_id[1] >= 0; om = m_id[2] >= 0; ow = m_id[3] >= 0;
    run = (m_mode == 0);
    cmt = (m_mode == 2);
    trap   = oe && (s.ec || s.mt);
    lu     = od && oe && s.mr && (s.rd != 5'd0) && (s.rd == s.rs1 || s.rd == s.rs2);
    memgo  = om && !s.busy;
    mroom  = !om || memgo;
    exgo   = oe && mroom && run && !trap;
    exroom = (!oe || exgo) && run && !trap;
    redir  = exgo && s.tk;
    idgo   = od && !lu && !redir && run && !trap;
    iss    = idgo && exroom;
    idroom = run && !trap && !redir && (!od || iss);
    kill   = redir || (run && trap) || cmt;
    e_vec = {idroom, idgo, exroom, exroom && !iss, exgo, mroom, memgo, kill, redir || cmt, cmt};
    if (s.rst) begin
      for (int k = 0; k < 4; k++) n_id[k] = -1;
      n_mode = 0; n_mret = 1'b0; n_cnt = 32'd0; n_next = m_next;
    end else begin
      n_id[3] = memgo ? m_id[2] : -1;
      n_id[2] = exgo ? m_id[1] : (memgo ? -1 : m_id[2]);
      n_id[1] = cmt ? -1 : iss ? m_id[0] : exgo ? -1 : m_id[1];
      n_id[0] = kill ? -1 : (s.fv && idroom) ? m_next : iss ? -1 : m_id[0];
      n_next  = (!kill && s.fv && idroom) ? m_next + 1 : m_next;
      if (run && trap)                       n_mode = 1;
      else if (m_mode == 1 && !om && !ow)    n_mode = 2;
      else if (cmt)                          n_mode = 0;
      else                                   n_mode = m_mode;
      n_mret = (run && trap) ? s.mt : m_mret;
      n_cnt  = (lu && run && !trap) ? m_cnt + 32'd1 : m_cnt;
    end
  endtask

  // Drive one cycle of stimulus and compare every output at the falling edge.
  task automatic drive_check(input stim_t s, input bit do_chk);
    reset = s.rst; Fvalid = s.fv; Rs1D = s.rs1; Rs2D = s.rs2; RdE = s.rd;
    MemReadE = s.mr; TakenE = s.tk; EcallE = s.ec; MretE = s.mt; MemBusy = s.busy;
    model_eval(s);
    @(negedge clk);
    if (do_chk) begin
      chk("Dready",     32'(Dready),     32'(e_vec[9]));
      chk("Dvalid",     32'(Dvalid),     32'(e_vec[8]));
      chk("Eready",     32'(Eready),     32'(e_vec[7]));
      chk("BubbleE",    32'(BubbleE),    32'(e_vec[6]));
      chk("Evalid",     32'(Evalid),     32'(e_vec[5]));
      chk("Mready",     32'(Mready),     32'(e_vec[4]));
      chk("Mvalid",     32'(Mvalid),     32'(e_vec[3]));
      chk("FlushD",     32'(FlushD),     32'(e_vec[2]));
      chk("RedirectF",  32'(RedirectF),  32'(e_vec[1]));
      chk("TrapCommit", 32'(TrapCommit), 32'(e_vec[0]));
      chk("TrapIsMret", 32'(TrapIsMret), 32'(m_mret));
      chk("LoadUseCnt", LoadUseCnt,      m_cnt);
    end
  endtask

  task automatic finish_cycle();
    for (int k = 0; k < 4; k++) m_id[k] = n_id[k];
    m_mode = n_mode; m_next = n_next; m_mret = n_mret; m_cnt = n_cnt;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input stim_t s);
    drive_check(s, 1'b1);
    finish_cycle();
  endtask

  task automatic run_reset(input bit do_chk);
    for (int k = 0; k < 2; k++) begin
      drive_check(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), do_chk);
      finish_cycle();
    end
  endtask

  vec_t tbl [9];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, evs, commit_at;
    bit done;
    stim_t s;

    for (int k = 0; k < 4; k++) m_id[k] = -1;
    m_mode = 0; m_next = 0; m_mret = 1'b0; m_cnt = 32'd0;
    reset = 1'b1; Fvalid = 1'b0; Rs1D = '0; Rs2D = '0; RdE = '0;
    MemReadE = 1'b0; TakenE = 1'b0; EcallE = 1'b0; MretE = 1'b0; MemBusy = 1'b0;
    @(posedge clk);
    #1;

    // Fill, load-use (rd=5 vs rs2=5), rd=0 load, taken transfer, refill.
    tbl[0] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 10'b1011010000, 32'd0};
    tbl[1] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 10'b1110010000, 32'd0};
    tbl[2] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 10'b1110110000, 32'd0};
    tbl[3] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 10'b1110111000, 32'd0};
    tbl[4] = '{mk(0, 1, 0, 5, 5, 1, 0, 0, 0, 0), 10'b0011111000, 32'd0};
    tbl[5] = '{mk(0, 1, 0, 5, 5, 1, 0, 0, 0, 0), 10'b1110011000, 32'd1};
    tbl[6] = '{mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0), 10'b1110110000, 32'd1};
    tbl[7] = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0), 10'b0011111110, 32'd1};
    tbl[8] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 10'b1011011000, 32'd1};

    run_reset(1'b0);
    chk("reset_TrapIsMret", 32'(TrapIsMret), 32'd0);
    for (int i = 0; i < 9; i++) begin
      drive_check(tbl[i].s, 1'b1);
      chk($sformatf("tbl%0d_vec", i), 32'(dut_vec()), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_cnt", i), LoadUseCnt, tbl[i].exp_cnt);
      finish_cycle();
    end

    // MemBusy for 3 cycles with a full pipe, then release.
    run_reset(1'b1);
    repeat (4) step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      drive_check(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
      chk("busy_Mvalid", 32'(Mvalid), 32'd0);
      chk("busy_Evalid", 32'(Evalid), 32'd0);
      chk("busy_Eready", 32'(Eready), 32'd0);
      chk("busy_Dready", 32'(Dready), 32'd0);
      finish_cycle();
    end
    drive_check(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    chk("release_Mvalid", 32'(Mvalid), 32'd1);
    chk("release_Evalid", 32'(Evalid), 32'd1);
    finish_cycle();

    // Ecall in EX while MEM is busy for 2 cycles: drain, then one commit.
    run_reset(1'b1);
    repeat (3) step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    pulses = 0; evs = 0; commit_at = -1; done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      drive_check(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, (i < 2) ? 1'b1 : 1'b0), 1'b1);
      if (Evalid === 1'b1) evs++;
      if (TrapCommit === 1'b1) begin
        pulses++;
        commit_at = i;
        done = 1'b1;
        chk("trap_RedirectF", 32'(RedirectF), 32'd1);
        chk("trap_IsMret", 32'(TrapIsMret), 32'd0);
      end
      finish_cycle();
    end
    chk("trap_pulses", 32'(pulses), 32'd1);
    chk("trap_commit_cycle", 32'(commit_at), 32'd5);
    chk("trap_evalid_cycles", 32'(evs), 32'd0);
    drive_check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    chk("post_trap_Dvalid", 32'(Dvalid), 32'd0);
    chk("post_trap_Evalid", 32'(Evalid), 32'd0);
    chk("post_trap_Mvalid", 32'(Mvalid), 32'd0);
    finish_cycle();

    // Reset while draining: no commit afterwards, pipe empty in RUN.
    run_reset(1'b1);
    repeat (3) step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) step(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1));
    step(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 1));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive_check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
      if (i == 0) chk("rst_drain_vec", 32'(dut_vec()), 32'(10'b1011010000));
      if (TrapCommit !== 1'b0) pulses++;
      finish_cycle();
    end
    chk("rst_drain_no_commit", 32'(pulses), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 199) == 0);
      s.fv   = ($urandom_range(0, 9) < 8);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rd   = 5'($urandom_range(0, 3));
      s.mr   = ($urandom_range(0, 9) < 3);
      s.tk   = ($urandom_range(0, 19) < 3);
      s.ec   = ($urandom_range(0, 39) == 0);
      s.mt   = ($urandom_range(0, 39) == 0);
      s.busy = ($urandom_range(0, 4) == 0);
      step(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
